// File: rtl/parity_check_rx.sv
// Even-parity checker for 5-bit codewords: good words go into a small FIFO,
// bad words are dropped and reported through an err pulse and a saturating counter.
module parity_check_rx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               DIN,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               DOUT,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err,
    output logic [CNT_W-1:0]         err_cnt,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic push_acc, good, push, bad, pop;

    // Handshake decode, FIFO bookkeeping and error accounting.
    always_comb begin
        push_acc = in_valid & in_ready_q;
        good     = ~(^DIN);
        push     = push_acc & good;
        bad      = push_acc & ~good;
        pop      = out_valid_q & out_ready;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = DIN[4:1];
        end

        // Pointer widths match log2(DEPTH), so wrap is the natural overflow.
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        level_d     = level_q + LW'(push) - LW'(pop);
        in_ready_d  = (level_d != LW'(DEPTH));
        out_valid_d = (level_d != '0);

        err_d     = bad;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = bad ? CNT_W'(1) : '0;
        end else if (bad && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage is left uncleared; out_valid guards its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign DOUT      = mem_q[rd_ptr_q];
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign level     = level_q;

endmodule

// File: doc/parity_check_rx.md
PARITY_CHECK_RX -- requirements
Module: parity_check_rx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of output FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the error counter width.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 The block SHALL have port DIN, input, 5, the codeword {data[3:0], parity}; bit 0 is the parity bit.
REQ-006 The block SHALL have port in_valid, input, 1, meaning DIN is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block can accept a codeword this cycle.
REQ-008 The block SHALL have port DOUT, output, 4, the checked data word at the FIFO head.
REQ-009 The block SHALL have port out_valid, output, 1, meaning DOUT is valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts DOUT.
REQ-011 The block SHALL have port err, output, 1, a one-cycle pulse when a parity error is detected.
REQ-012 The block SHALL have port err_cnt, output, CNT_W, the saturating count of parity errors.
REQ-013 The block SHALL have port err_clr, input, 1, a synchronous clear of err_cnt.
REQ-014 The block SHALL have port level, output, log2(DEPTH)+1, the current FIFO occupancy.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 Parity SHALL be even: a codeword is good when the XOR of all 5 DIN bits is 0 and bad otherwise (e.g. 5'b00110 good, 5'b10111 good, 5'b10110 bad).
REQ-017 A good codeword SHALL be enqueued as DIN[4:1]; a bad codeword SHALL be consumed (handshake completes) but not enqueued.
REQ-018 in_ready SHALL equal (level != DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL equal (level != 0); DOUT SHALL present the oldest entry, and its value when out_valid=0 is don't-care.
REQ-020 Latency from the accepting edge to out_valid=1 on an empty FIFO SHALL be exactly 1 cycle; there SHALL be no combinational path from DIN to DOUT.
REQ-021 Ordering SHALL be strict FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-022 On a simultaneous good push and pop, level SHALL be unchanged and both transfers SHALL complete.
REQ-023 A push when full SHALL be impossible (in_ready=0), and a pop when empty SHALL be impossible (out_valid=0); DOUT/level SHALL be unaffected by out_ready while empty.
REQ-024 err SHALL be 1 in the cycle after each bad-codeword transfer, for exactly one cycle per bad codeword; back-to-back bad codewords SHALL hold err=1 on consecutive cycles.
REQ-025 err_cnt SHALL increment by 1 per bad codeword and saturate at 2^CNT_W-1 with no wrap.
REQ-026 If err_clr=1 and a bad codeword transfers in the same cycle, err_cnt SHALL become 1; err_clr alone SHALL set it to 0.
REQ-027 The err flag and err_cnt SHALL be unaffected by FIFO full/empty state.

Reset
REQ-028 While rst=1 at a clock edge: level=0, out_valid=0, in_ready=1 (after the edge), err=0, err_cnt=0, and pointers SHALL be 0; FIFO storage need not be cleared.
REQ-029 Reset mid-operation SHALL discard all queued words and any pending err pulse; in_valid/out_ready SHALL be ignored during the reset cycle.
REQ-030 DOUT SHALL be don't-care after reset until the first push.

Verification
REQ-031 Push DIN=5'b00110 into an empty FIFO -> the next cycle gives out_valid=1, DOUT=4'b0011, level=1, err=0.
REQ-032 Push 5'b10111, 5'b11110, 5'b00110 back-to-back with out_ready=1 -> DOUT sequence 4'b1011, 4'b1111, 4'b0011 and err never 1.
REQ-033 Push 5'b10110 -> err=1 for one cycle, err_cnt=1, level stays 0, out_valid stays 0.
REQ-034 With out_ready=0, push 5 good words -> level=4 and in_ready=0 after the 4th; the 5th is held; raise out_ready -> FIFO order preserved and the 5th word is accepted.
REQ-035 With CNT_W=2, push 4 bad words -> err_cnt=3; then err_clr together with a bad word -> err_cnt=1.
REQ-036 With level=3, assert rst for one cycle -> level=0, out_valid=0, err_cnt=0; a subsequent push behaves as in REQ-031.
